// File: rtl/invsqrt_share_arbiter.sv
// Round-robin front end sharing one fixed-latency Q8.24 inverse-sqrt pipe among
// N_REQ requesters; a tag shift register steers each result back to its issuer.
module invsqrt_share_arbiter #(
    parameter int  WIDTH    = 32,
    parameter int  N_REQ    = 4,
    parameter int  PIPE_LAT = 3,
    localparam int ID_W     = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_x,
    output logic [N_REQ-1:0]       req_ready,
    input  logic                   hold,
    output logic                   pipe_valid_in,
    output logic [WIDTH-1:0]       pipe_x,
    input  logic                   pipe_valid_out,
    input  logic [WIDTH-1:0]       pipe_result,
    output logic [N_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]       resp_data,
    output logic                   idle,
    output logic                   err
);

    logic [WIDTH-1:0]    req_x_arr [N_REQ];
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     grant_id;
    logic                grant_found;
    logic [ID_W-1:0]     issue_id;
    logic [PIPE_LAT-1:0] tag_valid;
    logic [ID_W-1:0]     tag_id [PIPE_LAT];
    logic                head_valid;
    logic [ID_W-1:0]     head_id;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_x_arr[i] = req_x[i*WIDTH +: WIDTH];
        end
    end

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        logic [ID_W-1:0] cand;
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
        if (hold || rst) begin
            grant_found = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr        <= ID_W'(N_REQ - 1);
            pipe_valid_in <= 1'b0;
            pipe_x        <= '0;
            issue_id      <= '0;
        end else begin
            pipe_valid_in <= grant_found;
            if (grant_found) begin
                rr_ptr   <= grant_id;
                pipe_x   <= req_x_arr[grant_id];
                issue_id <= grant_id;
            end
        end
    end

    // Tag travels PIPE_LAT cycles behind the issue so it lines up with the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_valid[0] <= pipe_valid_in;
            tag_id[0]    <= issue_id;
            for (int i = 1; i < PIPE_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
        end
    end

    assign head_valid = tag_valid[PIPE_LAT-1];
    assign head_id    = tag_id[PIPE_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= '0;
            resp_data  <= '0;
            err        <= 1'b0;
        end else begin
            resp_valid <= '0;
            if (head_valid && pipe_valid_out) begin
                resp_valid[head_id] <= 1'b1;
                resp_data           <= pipe_result;
            end
            if (head_valid != pipe_valid_out) begin
                err <= 1'b1;
            end
        end
    end

    assign idle = !pipe_valid_in && (tag_valid == '0) && (resp_valid == '0);

endmodule
